washer_plant_monitor: RTL

- Plant-side counterpart to the washing-machine controller: consumes the actuator commands fill_valve, motor_wash, motor_spin and done.
- Models the drum water level and tracks the wash programme sequence.
- Flags illegal command sequences and counts completed programmes.
- Used in the FSM test environment as the closed-loop plant and protocol checker, and as a synthesizable health monitor.

---
 rtl/washer_plant_monitor.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/washer_plant_monitor.sv
// Closed-loop plant model and protocol checker for the washing-machine controller:
// models drum level, tracks the programme sequence, flags illegal command sequences.
module washer_plant_monitor #(
    parameter int unsigned LEVEL_W    = 8,
    parameter int unsigned FULL_LEVEL = 200,
    parameter int unsigned FILL_RATE  = 4,
    parameter int unsigned DRAIN_RATE = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               fill_valve,
    input  logic               motor_wash,
    input  logic               motor_spin,
    input  logic               done,
    input  logic               clear_err,
    output logic [LEVEL_W-1:0] water_level,
    output logic               level_full,
    output logic               drum_empty,
    output logic [2:0]         phase,
    output logic [CNT_W-1:0]   agitate_len,
    output logic [CNT_W-1:0]   cycles_done,
    output logic               underfill_warn,
    output logic               err,
    output logic [2:0]         err_code
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FILL    = 3'd1,
        AGITATE = 3'd2,
        SPIN    = 3'd3,
        DONE    = 3'd4,
        FAULT   = 3'd7
    } phase_t;

    localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

    phase_t              state;
    logic [LEVEL_W-1:0]  level;
    logic [LEVEL_W-1:0]  level_next;
    logic [LEVEL_W:0]    level_up;
    logic [CNT_W-1:0]    agit_cnt;
    logic [2:0]          n_cmd;
    logic                is_none;
    logic                overlap;
    logic [2:0]          new_code;
    logic                new_err;

    // Level model: spin drains and takes priority over fill; both saturate.
    always_comb begin
        level_up   = {1'b0, level} + (LEVEL_W+1)'(FILL_RATE);
        level_next = level;
        if (motor_spin)
            level_next = (level < LEVEL_W'(DRAIN_RATE)) ? '0 : level - LEVEL_W'(DRAIN_RATE);
        else if (fill_valve)
            level_next = (level_up > {1'b0, LEVEL_MAX}) ? LEVEL_MAX : level_up[LEVEL_W-1:0];
    end

    assign n_cmd   = 3'(fill_valve) + 3'(motor_wash) + 3'(motor_spin) + 3'(done);
    assign is_none = (n_cmd == 3'd0);
    assign overlap = (n_cmd > 3'd1);

    always_comb begin
        new_code = 3'd0;
        if (overlap)
            new_code = 3'd1;
        else begin
            case (state)
                IDLE:    if (!is_none && !fill_valve)      new_code = 3'd2;
                FILL:    if (!(fill_valve || motor_wash)) new_code = 3'd2;
                AGITATE: if (!(motor_wash || motor_spin)) new_code = 3'd2;
                SPIN:    if (!(motor_spin || done))       new_code = 3'd2;
                DONE:    if (done)                        new_code = 3'd3;
                         else if (!is_none)               new_code = 3'd2;
                default: new_code = 3'd0;
            endcase
        end
    end

    assign new_err = (new_code != 3'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            level          <= '0;
            agit_cnt       <= '0;
            agitate_len    <= '0;
            cycles_done    <= '0;
            underfill_warn <= 1'b0;
            err            <= 1'b0;
            err_code       <= 3'd0;
        end else begin
            level <= level_next;
            if (clear_err && (state != FAULT || is_none))
                underfill_warn <= 1'b0;

            if (new_err) begin
                state <= FAULT;
                err   <= 1'b1;
                // clear_err in the same cycle re-arms the first-error latch for the new cause
                if (!err || clear_err)
                    err_code <= new_code;
            end else begin
                case (state)
                    IDLE: if (fill_valve) state <= FILL;
                    FILL: if (motor_wash) begin
                        state    <= AGITATE;
                        agit_cnt <= CNT_W'(1);
                        if (!level_full)
                            underfill_warn <= 1'b1;
                    end
                    AGITATE: begin
                        if (motor_wash && agit_cnt != CNT_MAX)
                            agit_cnt <= agit_cnt + CNT_W'(1);
                        if (motor_spin) begin
                            state       <= SPIN;
                            agitate_len <= agit_cnt;
                        end
                    end
                    SPIN: if (done) state <= DONE;
                    DONE: if (is_none) begin
                        state       <= IDLE;
                        cycles_done <= cycles_done + CNT_W'(1);
                    end
                    FAULT: if (clear_err) begin
                        err      <= 1'b0;
                        err_code <= 3'd0;
                        if (is_none)
                            state <= IDLE;
                    end
                    default: state <= FAULT;
                endcase
            end
        end
    end

    assign water_level = level;
    assign level_full  = (level >= LEVEL_W'(FULL_LEVEL));
    assign drum_empty  = (level == '0);
    assign phase       = state;

endmodule
